// File: rtl/soda_pkg.sv
// Shared types for the soda dispenser controller: FSM state encoding and reset state.
package soda_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    WAIT = 2'd1,
    ADD  = 2'd2,
    DISP = 2'd3
  } soda_state_t;

  localparam soda_state_t SODA_RESET_STATE = INIT;

endpackage

// File: rtl/soda_control.sv
// Moore controller for the soda dispenser: sequences clear/load of the external
// total register and raises the dispense strobe once the total reaches the price.
//
// state | meaning
// INIT  | clear the running total (tot_clr)
// WAIT  | idle, sampling coin and comparator
// ADD   | load total + coin value (tot_ld)
// DISP  | dispense strobe (d), then back to INIT
module soda_control
  import soda_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic c,
  input  logic tot_lt_s,
  output logic tot_ld,
  output logic tot_clr,
  output logic d
);

  soda_state_t state_q;
  soda_state_t state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SODA_RESET_STATE;
    else      state_q <= state_d;
  end

  // A coin in WAIT takes priority over the price-reached check.
  always_comb begin
    state_d = INIT;
    case (state_q)
      INIT:    state_d = WAIT;
      WAIT: begin
        if (c)              state_d = ADD;
        else if (!tot_lt_s) state_d = DISP;
        else                state_d = WAIT;
      end
      ADD:     state_d = WAIT;
      DISP:    state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  // Outputs depend on the state register only, so no input reaches them combinationally.
  always_comb begin
    tot_clr = 1'b0;
    tot_ld  = 1'b0;
    d       = 1'b0;
    case (state_q)
      INIT:    tot_clr = 1'b1;
      ADD:     tot_ld  = 1'b1;
      DISP:    d       = 1'b1;
      default: ;
    endcase
  end

`ifdef SODA_ASSERT
  a_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0({tot_clr, tot_ld, d}));
  a_d_single: assert property (@(posedge clk) disable iff (!rst) d |=> !d);
  a_ld_cause: assert property (@(posedge clk) disable iff (!rst)
                               (state_q == WAIT && c) |=> tot_ld);
`endif

endmodule

// File: tb/tb_soda_control.sv
// Self-checking bench for soda_control: directed vector table, reset corner cases,
// and randomized traffic checked against an event-schedule reference model.
module tb_soda_control;

  logic clk;
  logic rst;
  logic c;
  logic tot_lt_s;
  logic tot_ld;
  logic tot_clr;
  logic d;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [2:0] O_CLR  = 3'b100;
  localparam logic [2:0] O_LD   = 3'b010;
  localparam logic [2:0] O_D    = 3'b001;
  localparam logic [2:0] O_NONE = 3'b000;

  typedef struct {
    logic       rst;
    logic       c;
    logic       lt;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[16];

  // Reference: a queue of outputs the controller still owes; empty means ready for input.
  logic [2:0] sched_q[$];

  soda_control dut (
    .clk      (clk),
    .rst      (rst),
    .c        (c),
    .tot_lt_s (tot_lt_s),
    .tot_ld   (tot_ld),
    .tot_clr  (tot_clr),
    .d        (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = {tot_clr, tot_ld, d};
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got clr/ld/d=%b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic cc, input logic lt);
    if (!r) begin
      sched_q.delete();
      sched_q.push_back(O_CLR);
    end else if (sched_q.size() != 0) begin
      void'(sched_q.pop_front());
    end else if (cc) begin
      sched_q.push_back(O_LD);
    end else if (!lt) begin
      sched_q.push_back(O_D);
      sched_q.push_back(O_CLR);
    end
  endtask

  function automatic logic [2:0] model_out();
    return (sched_q.size() != 0) ? sched_q[0] : O_NONE;
  endfunction

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, O_CLR};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, O_CLR};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, O_NONE};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, O_LD};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, O_NONE};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, O_NONE};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, O_LD};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, O_NONE};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, O_D};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, O_CLR};
    vecs[10] = '{1'b1, 1'b1, 1'b0, O_NONE};
    vecs[11] = '{1'b1, 1'b1, 1'b0, O_LD};
    vecs[12] = '{1'b1, 1'b0, 1'b0, O_NONE};
    vecs[13] = '{1'b1, 1'b0, 1'b0, O_D};
    vecs[14] = '{1'b1, 1'b0, 1'b1, O_CLR};
    vecs[15] = '{1'b1, 1'b0, 1'b1, O_NONE};

    rst = 1'b0;
    c = 1'b1;
    tot_lt_s = 1'b0;
    #1;
    check("reset_hold", O_CLR);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      c = vecs[i].c;
      tot_lt_s = vecs[i].lt;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset asserted while in ADD aborts immediately and holds INIT.
    @(negedge clk);
    c = 1'b1;
    tot_lt_s = 1'b1;
    @(posedge clk);
    #1;
    check("mid_add_enter", O_LD);
    #2;
    rst = 1'b0;
    #1;
    check("mid_add_reset", O_CLR);
    @(negedge clk);
    c = 1'b0;
    @(posedge clk);
    #1;
    check("mid_add_hold", O_CLR);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_add_release", O_NONE);

    // Reset asserted while in DISP.
    @(negedge clk);
    tot_lt_s = 1'b0;
    @(posedge clk);
    #1;
    check("mid_disp_enter", O_D);
    #2;
    rst = 1'b0;
    #1;
    check("mid_disp_reset", O_CLR);
    @(negedge clk);
    rst = 1'b1;
    tot_lt_s = 1'b1;
    @(posedge clk);
    #1;
    check("mid_disp_release", O_NONE);

    sched_q.delete();
    for (int i = 0; i < 3000; i++) begin
      logic r_v, c_v, lt_v;
      @(negedge clk);
      r_v = ($urandom_range(0, 49) != 0);
      c_v = ($urandom_range(0, 3) == 0);
      lt_v = ($urandom_range(0, 2) != 0);
      rst = r_v;
      c = c_v;
      tot_lt_s = lt_v;
      @(posedge clk);
      model_edge(r_v, c_v, lt_v);
      #1;
      check($sformatf("rand%0d", i), model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
